// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed, active-low 4-digit 7-segment scan back into hex nibbles.
// Each anode dwell is debounced, captured once, and complete frames are published as a snapshot.
module seg_scan_decoder #(
    parameter int SETTLE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [15:0] frame_digits,
    output logic        frame_valid,
    output logic        err
);

    localparam logic [15:0] SETTLE_C = SETTLE[15:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HELD   = 2'd2
    } state_t;

    // Returns {hit, nibble} for an active-low segment pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // True when exactly one anode strobe is low.
    function automatic logic one_low(input logic [3:0] a);
        logic r;
        case (a)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Position of the single low anode (only meaningful when one_low holds).
    function automatic logic [1:0] low_pos(input logic [3:0] a);
        logic [1:0] r;
        case (a)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    logic [10:0] in_r;
    logic [10:0] prev_r;
    logic [15:0] cnt_r;
    logic [15:0] cnt_next_s;
    state_t      state_r;
    state_t      state_next_s;
    logic        changed_s;
    logic        idle_in_s;
    logic        attempt_s;
    logic [4:0]  dec_s;
    logic [1:0]  pos_s;
    logic        cap_ok_s;
    logic        cap_bad_s;
    logic [3:0]  sel_s;
    logic [3:0]  seen_r;
    logic [3:0]  seen_upd_s;
    logic        frame_set_s;
    logic        frame_pend_r;
    logic [15:0] digits_r;
    logic [15:0] digits_next_s;
    logic [3:0]  dv_r;
    logic [3:0]  dv_next_s;
    logic [15:0] frame_digits_r;
    logic        frame_valid_r;
    logic        err_r;

    // Input sample register and its one-cycle-delayed copy for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_r   <= 11'h7FF;
            prev_r <= 11'h7FF;
        end else begin
            in_r   <= {an, seg};
            prev_r <= in_r;
        end
    end

    // Stability counter next value and the single capture attempt per dwell.
    always_comb begin
        changed_s  = (in_r != prev_r);
        idle_in_s  = (in_r[10:7] == 4'hF);
        cnt_next_s = cnt_r;
        if (changed_s) begin
            cnt_next_s = 16'd1;
        end else if (cnt_r < SETTLE_C) begin
            cnt_next_s = cnt_r + 16'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
        attempt_s = !idle_in_s && (cnt_next_s == SETTLE_C) &&
                    (changed_s || (state_r == S_SETTLE));
    end

    // Dwell FSM next state; a blank anode pattern always parks in IDLE.
    always_comb begin
        state_next_s = state_r;
        if (idle_in_s) begin
            state_next_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (attempt_s)      state_next_s = S_HELD;
                    else if (changed_s) state_next_s = S_SETTLE;
                    else                state_next_s = S_IDLE;
                end
                S_SETTLE: begin
                    if (attempt_s) state_next_s = S_HELD;
                    else           state_next_s = S_SETTLE;
                end
                S_HELD: begin
                    if (attempt_s)      state_next_s = S_HELD;
                    else if (changed_s) state_next_s = S_SETTLE;
                    else                state_next_s = S_HELD;
                end
                default: state_next_s = S_IDLE;
            endcase
        end
    end

    // Counter and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 16'd0;
            state_r <= S_IDLE;
        end else begin
            cnt_r   <= cnt_next_s;
            state_r <= state_next_s;
        end
    end

    // Classify the capture attempt and compute the updated digit/valid/seen values.
    always_comb begin
        dec_s     = seg_decode(in_r[6:0]);
        pos_s     = low_pos(in_r[10:7]);
        cap_ok_s  = attempt_s && one_low(in_r[10:7]) && dec_s[4];
        cap_bad_s = attempt_s && !(one_low(in_r[10:7]) && dec_s[4]);
        sel_s         = 4'b0000;
        digits_next_s = digits_r;
        dv_next_s     = dv_r;
        if (cap_ok_s) begin
            sel_s = 4'b0001 << pos_s;
            digits_next_s[{pos_s, 2'b00} +: 4] = dec_s[3:0];
            dv_next_s = dv_r | sel_s;
        end else if (cap_bad_s) begin
            dv_next_s = dv_r & in_r[10:7];
        end else begin
            dv_next_s = dv_r;
        end
        // A pending frame means seen is being cleared on this edge.
        seen_upd_s  = (frame_pend_r ? 4'b0000 : seen_r) | sel_s;
        frame_set_s = cap_ok_s && (seen_upd_s == 4'hF);
    end

    // Capture results, frame publication and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_r       <= 16'h0000;
            dv_r           <= 4'h0;
            seen_r         <= 4'h0;
            frame_pend_r   <= 1'b0;
            frame_valid_r  <= 1'b0;
            frame_digits_r <= 16'h0000;
            err_r          <= 1'b0;
        end else begin
            digits_r      <= digits_next_s;
            dv_r          <= dv_next_s;
            seen_r        <= seen_upd_s;
            frame_pend_r  <= frame_set_s;
            frame_valid_r <= frame_pend_r;
            err_r         <= cap_bad_s;
            if (frame_pend_r) begin
                frame_digits_r <= digits_r;
            end else begin
                frame_digits_r <= frame_digits_r;
            end
        end
    end

    assign digits       = digits_r;
    assign digit_valid  = dv_r;
    assign frame_digits = frame_digits_r;
    assign frame_valid  = frame_valid_r;
    assign err          = err_r;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 16, meaning consecutive identical {an,seg} samples required before a capture (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port an  input  4  active-low anode strobes, an[3] is the leftmost digit.
REQ-005 SHALL have port seg  input  7  active-low segments, seg[0]=a through seg[6]=g.
REQ-006 SHALL have port digits  output  16  last captured nibble per position, an[3] maps to digits[15:12] and an[0] to digits[3:0].
REQ-007 SHALL have port digit_valid  output  4  bit i set when digits nibble i holds a valid capture.
REQ-008 SHALL have port frame_digits  output  16  snapshot of digits published at each frame completion.
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when frame_digits updates.
REQ-010 SHALL have port err  output  1  one-cycle pulse on a rejected capture.

Function
REQ-011 SHALL register {an,seg} each cycle and keep a 16-bit stability counter that loads 1 whenever the registered value differs from the previous registered value, and otherwise increments saturating at SETTLE.
REQ-012 SHALL perform exactly one capture attempt per dwell: on the edge where the counter reaches SETTLE.
REQ-013 SHALL use the FSM states IDLE, SETTLE and HELD.
REQ-014 SHALL transition from IDLE or HELD to SETTLE on any input change.
REQ-015 SHALL transition from SETTLE to HELD when the capture attempt fires.
REQ-016 SHALL transition from any state to IDLE when an is 4'b1111, and SHALL make no capture attempt while in IDLE.
REQ-017 SHALL treat a capture attempt as valid only when exactly one an bit is low and seg matches the decode table.
REQ-018 SHALL use this decode table, seg hex giving value: 40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7, 00=8, 10=9, 08=A, 03=b, 46=C, 21=d, 06=E, 0E=F.
REQ-019 SHALL, on a valid capture, write the decoded nibble to the selected position and set its digit_valid bit on the same edge.
REQ-020 SHALL, on an invalid capture (multiple anodes low, or seg not in the table, including blank 7F), pulse err, clear the digit_valid bit of every low anode, and leave digits unchanged.
REQ-021 SHALL keep a 4-bit seen mask, setting bit i on each valid capture of position i.
REQ-022 SHALL, when a valid capture makes seen equal 4'b1111, pulse frame_valid and load frame_digits on the following edge, using digits as updated by that capture, and SHALL clear seen on the same edge as the pulse.
REQ-023 SHALL NOT complete a frame from repeated captures of the same position, and SHALL NOT reset seen on an invalid capture.
REQ-024 SHALL NOT change frame_digits except on a frame_valid pulse.
REQ-025 SHALL NOT capture twice within one dwell, however long the dwell.
REQ-026 SHALL have a capture latency of SETTLE cycles after the first cycle of the new value appears at the input register.

Reset
REQ-027 SHALL, while rst_n is low, force digits=0, digit_valid=0, frame_digits=0, frame_valid=0, err=0, seen=0, counter=0, FSM=IDLE and the input register to {4'hF,7'h7F}.
REQ-028 SHALL, on reset asserted mid-dwell or mid-frame, discard partial progress, and SHALL start the first capture after release only after a fresh SETTLE-sample dwell.

Verification
REQ-029 SHALL be verified with SETTLE=4 by scanning an 0111/1011/1101/1110 with seg 79/24/30/19 (8 cycles each) -> digits=16'h1234, digit_valid=F, a single frame_valid pulse, and frame_digits=16'h1234.
REQ-030 SHALL be verified with SETTLE=4 by driving an=1110 with seg=00 for 3 cycles followed by a change -> no capture, digit_valid[0]=0, no err.
REQ-031 SHALL be verified by driving an=1100 with seg=40, stable, after a full frame -> one err pulse, digit_valid=4'b1100, digits and frame_digits unchanged.
REQ-032 SHALL be verified by driving an=0111 with seg=7F (blank) -> err pulse, digit_valid[3]=0, seen unaffected, and no frame until position 3 next decodes validly.
REQ-033 SHALL be verified by holding an=1110 with seg=46 for 1000 cycles -> exactly one capture, digits[3:0]=C, no frame_valid.
REQ-034 SHALL be verified by asserting rst_n low after 3 positions are captured, then releasing -> all outputs 0, and frame_valid only after all 4 positions are recaptured.
